// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard unit for the pipelined rv32i core. Tracks destination
// tags for EX..WB and resolves each decode source against the youngest in-flight producer.
module fwd_scoreboard #(
  parameter int          XLEN         = 32,
  parameter int          NUM_SRC      = 2,
  parameter int          NUM_STG      = 3,
  parameter int          LOAD_RDY_STG = 2,
  parameter logic [31:0] CNT_RST_VAL  = 32'd0,
  localparam int         SEL_W        = $clog2(NUM_STG + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           id_valid,
  input  logic [NUM_SRC-1:0][4:0]        id_rs,
  input  logic [NUM_SRC-1:0]             id_rs_used,
  input  logic [4:0]                     id_rd,
  input  logic                           id_we,
  input  logic                           id_is_load,
  input  logic                           pipe_advance,
  input  logic                           flush,
  input  logic [NUM_STG-1:0][XLEN-1:0]   stage_data,
  input  logic [NUM_SRC-1:0][XLEN-1:0]   rf_data,
  output logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel,
  output logic [NUM_SRC-1:0][XLEN-1:0]   fwd_data,
  output logic                           stall_id,
  output logic [31:0]                    stall_cnt
);

  logic [NUM_STG-1:0]      vld_q, vld_d;
  logic [NUM_STG-1:0]      we_q, we_d;
  logic [NUM_STG-1:0]      ld_q, ld_d;
  logic [NUM_STG-1:0][4:0] rd_q, rd_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [NUM_SRC-1:0]      hit;
  logic                    ld_hazard;
  logic                    accept;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Source resolution; LOAD_RDY_STG is in fwd_sel units, so a load in stage k
  // is usable once k+1 >= LOAD_RDY_STG (default: usable from MEM).
  always_comb begin
    ld_hazard = 1'b0;
    hit       = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_sel[s]  = '0;
      fwd_data[s] = rf_data[s];
      for (int k = 0; k < NUM_STG; k++) begin
        if (!hit[s] && id_valid && id_rs_used[s] && vld_q[k] && we_q[k] &&
            (rd_q[k] == id_rs[s]) && (id_rs[s] != 5'd0)) begin
          hit[s]      = 1'b1;
          fwd_sel[s]  = SEL_W'(k + 1);
          fwd_data[s] = stage_data[k];
          if (ld_q[k] && ((k + 1) < LOAD_RDY_STG)) ld_hazard = 1'b1;
        end
      end
    end
  end

  assign stall_id  = ld_hazard & ~flush;
  assign stall_cnt = cnt_q;
  assign accept    = id_valid & ~stall_id & ~flush;

  always_comb begin
    vld_d = vld_q;
    we_d  = we_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    if (pipe_advance) begin
      for (int k = NUM_STG - 1; k >= 1; k--) begin
        vld_d[k] = vld_q[k-1];
        we_d[k]  = we_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      vld_d[0] = accept;
      we_d[0]  = id_we;
      ld_d[0]  = id_is_load;
      rd_d[0]  = id_rd;
    end
    cnt_d = stall_id ? sat_inc(cnt_q) : cnt_q;
  end

  // Stage boundary: shadow tags advance with the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= CNT_RST_VAL;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q <= we_d;
    ld_q <= ld_d;
    rd_q <= rd_d;
  end

endmodule
